// File: rtl/detector_pkg.sv
// Shared types and defaults for the serial pattern-detection session controller.
//   state_t  : controller FSM states (IDLE / RUN / DONE)
//   PAT_1011 : classic default target pattern
//   DEF_*    : default widths used as parameter defaults by the RTL
package detector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_LEN_W = 10;
  localparam int DEF_CNT_W = 8;

  localparam logic [DEF_PAT_W-1:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/pattern_detector_mealy.sv
// Programmable Mealy pattern detector.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : synchronous history/fill clear (session start)
//   bit_valid    : sequence_in is to be consumed this cycle
//   sequence_in  : serial data bit
//   pattern      : target pattern, MSB is the oldest bit
//   overlap      : 1 = keep history after a match, 0 = restart after a match
//   match        : combinational, high in the same cycle as the completing bit
module pattern_detector_mealy
  import detector_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             bit_valid,
  input  logic             sequence_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W) + 1;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0] hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0] window;

  // Candidate window: the PAT_W-1 stored bits plus the bit arriving now.
  assign window = {hist, sequence_in};
  assign match  = bit_valid && (fill >= FULL) && (window == pattern);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      hist <= '0;
      fill <= '0;
    end else if (bit_valid) begin
      hist <= window[PAT_W-2:0];
      // Non-overlapping mode only needs to forget the fill; stale history
      // bits are masked until fill reaches PAT_W-1 again.
      if (match && !overlap)
        fill <= '0;
      else if (fill != FULL)
        fill <= fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/detector_session_ctrl.sv
// Session controller around the Mealy pattern detector.
//   start/pattern/window_len : session request, pattern and length are latched
//                              when start is accepted in IDLE
//   sequence_in/bit_valid    : serial data stream
//   busy/done                : session running / one-cycle end-of-session pulse
//   match_pulse              : registered match indication
//   match_count              : saturating match count for the session
//   first_found/first_match_idx : whether and where the first match completed
module detector_session_ctrl
  import detector_pkg::*;
#(
  parameter int PAT_W   = DEF_PAT_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int OVERLAP = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] window_len,
  input  logic             sequence_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             first_found,
  output logic [LEN_W-1:0] first_match_idx
);

  state_t state, state_nxt;

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bits_seen;
  logic             accept;
  logic             det_valid;
  logic             last_bit;
  logic             match;

  assign accept    = (state == IDLE) && start;
  // Bits are consumed only while running; IDLE/DONE traffic never reaches the detector.
  assign det_valid = (state == RUN) && bit_valid;
  assign last_bit  = det_valid && ((bits_seen + LEN_W'(1)) == len_q);

  pattern_detector_mealy #(.PAT_W(PAT_W)) u_det (
    .clock       (clock),
    .reset       (reset),
    .clear       (accept),
    .bit_valid   (det_valid),
    .sequence_in (sequence_in),
    .pattern     (pat_q),
    .overlap     (OVERLAP != 0),
    .match       (match)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (window_len == '0) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pat_q           <= '0;
      len_q           <= '0;
      bits_seen       <= '0;
      match_pulse     <= 1'b0;
      match_count     <= '0;
      first_found     <= 1'b0;
      first_match_idx <= '0;
    end else begin
      match_pulse <= match;
      if (accept) begin
        pat_q           <= pattern;
        len_q           <= window_len;
        bits_seen       <= '0;
        match_count     <= '0;
        first_found     <= 1'b0;
        first_match_idx <= '0;
      end else if (det_valid) begin
        bits_seen <= bits_seen + LEN_W'(1);
        if (match && (match_count != '1))
          match_count <= match_count + CNT_W'(1);
        if (match && !first_found) begin
          first_found     <= 1'b1;
          first_match_idx <= bits_seen;
        end
      end
    end
  end

endmodule

// File: doc/detector_session_ctrl.md
# detector_session_ctrl

Session controller for bit-serial pattern detection. Under a start/busy/done handshake it runs a programmable Mealy pattern detector over a window of `window_len` valid input bits, then reports the match count and the index of the first match. It sits between the serial input stream and the host/register side. It generalises the fixed 1011 detector into a detector that can be armed and measured.

## Interface
Parameters:
- `PAT_W`, default 4: pattern length in bits.
- `LEN_W`, default 10: width of the window length and of the bit index.
- `CNT_W`, default 8: width of the match counter.
- `OVERLAP`, default 1: 1 = overlapping matches allowed; 0 = history cleared after each match.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous active-high reset.
- `start`  in  1  session request; sampled only in IDLE.
- `pattern`  in  PAT_W  target pattern; MSB is the oldest bit; latched at start.
- `window_len`  in  LEN_W  number of valid bits to examine; latched at start.
- `sequence_in`  in  1  serial data bit.
- `bit_valid`  in  1  `sequence_in` is valid this cycle.
- `busy`  out  1  session running.
- `done`  out  1  one-cycle pulse at session end.
- `match_pulse`  out  1  registered; high one cycle after a match-completing bit.
- `match_count`  out  CNT_W  matches this session; saturating.
- `first_found`  out  1  at least one match occurred.
- `first_match_idx`  out  LEN_W  0-based index of the bit that completed the first match.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On `start`=1, latch `pattern`, `window_len` and `OVERLAP` behaviour.
  - Clear history, fill count, `bits_seen`, `match_count`, `first_found` and `first_match_idx`.
  - Go to RUN, or to DONE directly if `window_len`=0.
- RUN:
  - Each cycle with `bit_valid`=1, shift `sequence_in` into the detector and increment `bits_seen`.
  - Cycles with `bit_valid`=0 leave all state unchanged.
  - Go to DONE on the valid bit where `bits_seen`+1 = latched length.
- DONE: assert `done` for one cycle, then return to IDLE.
- Results hold until the next accepted start.
- Detector: PAT_W-1-bit history plus fill counter. Match when fill ≥ PAT_W-1 and {history, `sequence_in`} == pattern (Mealy, same cycle as the bit).
  - OVERLAP=0: a match clears the fill to 0.
  - OVERLAP=1: history keeps shifting after a match.
- Counter: increments on each match, saturates at 2^CNT_W-1 and never wraps.
- First match: on the first match, `first_match_idx` ← current `bits_seen` and `first_found` ← 1.
- `start` while busy or in DONE: ignored. Changes to `pattern`/`window_len` mid-session: ignored.
- Reset at any time: FSM to IDLE, all outputs 0, history cleared. A session in flight is abandoned with no `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `match_pulse`=0, `match_count`=0, `first_found`=0, `first_match_idx`=0.
- `start` in cycle t → `busy`=1 from t+1; the first bit can be sampled at t+1.
- A match-completing bit in cycle k → `match_pulse` at k+1. `match_count`/`first_*` update at the k→k+1 edge.
- Last valid bit in cycle k → `busy`=0 and `done`=1 at k+1. Results are stable at k+1.
- `window_len`=0: `start` at t → `done` at t+1, `busy` stays 0, count 0.
- Next `start` is accepted the cycle after `done`, i.e. back-to-back sessions with a one-cycle gap.

## Structure
- Shared package `detector_pkg`: state enum (IDLE/RUN/DONE), a default pattern constant `PAT_1011` = 4'b1011, and default widths.
- Natural sub-module: `pattern_detector_mealy`.
  - Inputs: `clock`, `reset`, `clear`, `bit_valid`, `sequence_in`, `pattern`, `overlap`.
  - Output: combinational `match`.
- The controller owns the FSM, the counters and the latching.

## Test plan
- pattern=1011, OVERLAP=1, len=7, stream 1,0,1,1,0,1,1 (all valid) → `match_pulse` after bits 3 and 6; `match_count`=2, `first_match_idx`=3, `done` one cycle after bit 6.
- Same stream with OVERLAP=0 → `match_count`=1, `first_match_idx`=3.
- pattern=1011, len=4, bits 1,0,1,1 with `bit_valid` low for 3 cycles between each → count 1, `done` exactly one cycle after the 4th valid bit, `busy` high throughout.
- CNT_W=2, pattern=1111, OVERLAP=1, len=8, all ones → 5 raw matches, `match_count` saturates at 3, `first_match_idx`=3.
- `window_len`=0 → `done` at t+1, `busy` never 1, count 0, `first_found`=0. Also: `start` pulsed during RUN is ignored, and the session length is unchanged.
- `reset` asserted mid-session after 2 matches → next cycle all outputs 0, state IDLE, no `done`. A new session then counts from 0.
